ball_ctl: RTL
=============

// Module: ball_ctl
// PURPOSE
//  Ball motion controller for Arkanoid; sits directly upstream of the ball draw stage.
//  Once per frame it moves the ball centre by a fixed step per axis and bounces it off
//  the left, right and top walls and off the paddle. It detects ball loss at the bottom.
//  Its x_pos/y_pos outputs drive the draw stage's circle test; they are stable through active video.
// PARAMETERS
//  H_RES     1024  visible width, px; x valid range 0..H_RES-1
//  V_RES     768   visible height, px; y valid range 0..V_RES-1
//  BALL_R    10    ball radius, px; draw stage paints (dx^2+dy^2) <= BALL_R^2
//  STEP      4     px moved per axis per frame; must be < BALL_R
//  PADDLE_Y  740   top edge (row) of paddle
//  PADDLE_W  128   paddle width, px; paddle spans [paddle_x, paddle_x+PADDLE_W-1]
// PORTS
//  pclk       in   1   pixel clock; single clock domain
//  reset_n    in   1   asynchronous, active-low reset
//  vblnk_in   in   1   vertical blank from timing chain; rising edge = frame tick
//  start      in   1   launch request, level; sampled only in IDLE
//  paddle_x   in   11  paddle left edge, px; clamped by source to 0..H_RES-PADDLE_W
//  x_pos      out  11  ball centre column
//  y_pos      out  11  ball centre row
//  ball_lost  out  1   one-cycle pulse on entry to LOST
//  moving     out  1   high while state==MOVE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, x_pos=paddle_x+PADDLE_W/2 at first tick,
//   x_pos=H_RES/2 and y_pos=PADDLE_Y-BALL_R-1 while in reset; dir_x=+1 (right), dir_y=-1 (up);
//   ball_lost=0, moving=0, vblnk_d=0.
//  Frame tick: tick = vblnk_in & ~vblnk_d (vblnk_d registered). All position/state updates
//   happen only on the clock edge where tick=1; outputs change 1 cycle after the vblnk rising
//   edge. Outputs are constant for the rest of the frame.
//  States:
//   IDLE: every tick, x_pos<=paddle_x+PADDLE_W/2, y_pos<=PADDLE_Y-BALL_R-1. If start=1 on a tick,
//    go to MOVE with dir_x=+1, dir_y=-1; the first movement happens on the next tick.
//   MOVE: compute nx=x±STEP and ny=y±STEP in 12-bit signed arithmetic (no wrap), then apply:
//    left wall:  dir_x=-1 & nx<=BALL_R         -> x<=BALL_R, dir_x<=+1
//    right wall: dir_x=+1 & nx>=H_RES-1-BALL_R -> x<=H_RES-1-BALL_R, dir_x<=-1
//    top wall:   dir_y=-1 & ny<=BALL_R         -> y<=BALL_R, dir_y<=+1
//    paddle:     dir_y=+1 & y+BALL_R<PADDLE_Y & ny+BALL_R>=PADDLE_Y &
//                paddle_x<=nx<=paddle_x+PADDLE_W-1 -> y<=PADDLE_Y-BALL_R-1, dir_y<=-1
//    miss:       dir_y=+1 & ny+BALL_R>=V_RES-1 -> LOST, ball_lost=1 for one cycle
//    otherwise x<=nx, y<=ny.
//   Corner case: the x and y rules are evaluated independently, so both directions flip on the same tick.
//   Paddle has priority over miss; miss is only reachable once the ball is below the paddle row.
//   LOST: position frozen. On the next tick, go to IDLE (ball re-parks on paddle).
//  start is ignored outside IDLE. paddle_x is sampled only on ticks.
//  Reset mid-frame or mid-MOVE returns immediately to reset values; no partial update.
//  moving is registered and equals (state==MOVE).
// STRUCTURE
//  Shared header arcanoid_defs.vh: H_RES, V_RES, BALL_R, PADDLE_Y, PADDLE_W, and state
//   encodings ST_IDLE=2'd0, ST_MOVE=2'd1, ST_LOST=2'd2; the draw stages include the same file.
//  One sub-module, ball_axis: per-axis step/clamp/reflect (pos, dir, lo, hi limit -> next pos,
//   next dir, hit flag), instantiated once for x and once for y. The FSM, paddle test and tick
//   detector stay in ball_ctl.
// TESTING
//  1 Reset: reset_n=0 mid-line -> x_pos=512, y_pos=729, moving=0, ball_lost=0 immediately.
//  2 Park/launch: paddle_x=200, 2 ticks -> x_pos=264, y_pos=729. Raise start, then 1 tick ->
//    moving=1. Next tick -> (268,725).
//  3 Right wall: MOVE, dir_x=+1, x_pos=1010 -> next tick x_pos=1013, dir_x=-1. Next tick -> 1009.
//  4 Top-left corner: x_pos=12, y_pos=12, both dirs negative -> (10,10). Next tick -> (14,14).
//  5 Paddle hit: dir_y=+1, y_pos=728, paddle_x=100, x_pos=150 -> y_pos=729, dir_y=-1.
//    Same setup with paddle_x=400 -> ball passes, ball_lost pulses at ny>=757, then IDLE on next tick.
//  6 No-tick stability: hold vblnk_in=1 for 3 frames' worth of cycles -> exactly one update.
//    start pulsed outside a tick -> no launch.

Source files
------------

// File: rtl/ball_ctl_pkg.sv
// ball_ctl_pkg
//   Shared geometry constants, the coordinate type and the state encoding for
//   the ball motion controller. The draw stages import the same package, so
//   screen size and paddle geometry stay consistent across the video pipeline.
//   No ports; this is a package.
package ball_ctl_pkg;

  localparam int H_RES    = 1024;
  localparam int V_RES    = 768;
  localparam int BALL_R   = 10;
  localparam int STEP     = 4;
  localparam int PADDLE_Y = 740;
  localparam int PADDLE_W = 128;

  // Signed coordinates one bit wider than the outputs, so a step past the
  // screen edge shows up as a value beyond the limit instead of wrapping.
  typedef logic signed [11:0] coord_t;

  localparam coord_t STEP_C   = coord_t'(STEP);
  localparam coord_t RADIUS_C = coord_t'(BALL_R);
  localparam coord_t X_MIN    = coord_t'(BALL_R);
  localparam coord_t X_MAX    = coord_t'(H_RES - 1 - BALL_R);
  localparam coord_t Y_MIN    = coord_t'(BALL_R);
  // The y axis has no bottom wall; the paddle/miss logic owns that edge, so
  // the upper limit is parked at a value the ball can never reach.
  localparam coord_t Y_NONE   = 12'sh7FF;
  localparam coord_t PAD_TOP  = coord_t'(PADDLE_Y);
  localparam coord_t PAD_SPAN = coord_t'(PADDLE_W - 1);
  localparam coord_t FLOOR_C  = coord_t'(V_RES - 1);

  localparam logic [10:0] RESET_X     = 11'(H_RES / 2);
  localparam logic [10:0] PARK_Y      = 11'(PADDLE_Y - BALL_R - 1);
  localparam logic [10:0] HALF_PADDLE = 11'(PADDLE_W / 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_LOST = 2'd2
  } state_t;

  function automatic coord_t widen(input logic [10:0] v);
    return coord_t'({1'b0, v});
  endfunction

endpackage

// File: rtl/ball_ctl_axis.sv
// ball_axis
//   Purely combinational per-axis motion: step the position one STEP in the
//   current direction, then clamp and reflect against the low/high limits.
// Ports
//   pos      in  11  current centre coordinate
//   dir      in  1   1 = increasing coordinate, 0 = decreasing
//   lo, hi   in  12  signed limits; reaching or passing one clamps and reflects
//   raw      out 12  unclamped stepped coordinate (used for paddle/miss tests)
//   next_pos out 11  clamped coordinate to load on the frame tick
//   next_dir out 1   direction after any reflection
module ball_axis
  import ball_ctl_pkg::*;
(
  input  logic [10:0] pos,
  input  logic        dir,
  input  coord_t      lo,
  input  coord_t      hi,
  output coord_t      raw,
  output logic [10:0] next_pos,
  output logic        next_dir
);

  always_comb begin
    raw      = dir ? widen(pos) + STEP_C : widen(pos) - STEP_C;
    next_pos = raw[10:0];
    next_dir = dir;
    if (!dir && raw <= lo) begin
      next_pos = lo[10:0];
      next_dir = 1'b1;
    end else if (dir && raw >= hi) begin
      next_pos = hi[10:0];
      next_dir = 1'b0;
    end
  end

endmodule

// File: rtl/ball_ctl.sv
// ball_ctl
//   Arkanoid ball motion controller. Once per frame (rising edge of vblnk_in)
//   it parks the ball on the paddle, or moves it and bounces it off the walls
//   and the paddle, or reports a lost ball. Outputs only change on the cycle
//   after the frame tick, so they are stable through active video.
// Ports
//   pclk      in  1   pixel clock
//   reset_n   in  1   asynchronous active-low reset (released synchronously)
//   vblnk_in  in  1   vertical blank; its rising edge is the frame tick
//   start     in  1   launch request, only looked at on a tick while parked
//   paddle_x  in  11  paddle left edge
//   x_pos     out 11  ball centre column
//   y_pos     out 11  ball centre row
//   ball_lost out 1   one-cycle pulse when the ball falls past the paddle
//   moving    out 1   high while the ball is in flight
module ball_ctl
  import ball_ctl_pkg::*;
(
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        vblnk_in,
  input  logic        start,
  input  logic [10:0] paddle_x,
  output logic [10:0] x_pos,
  output logic [10:0] y_pos,
  output logic        ball_lost,
  output logic        moving
);

  logic [1:0]  rst_sync;
  logic        rst_n;
  logic        vblnk_d;
  logic        tick;
  state_t      state, state_nx;
  logic        dir_x, dir_y, dir_x_nx, dir_y_nx;
  logic [10:0] x_nx, y_nx;
  logic        lost_nx;
  coord_t      nx_raw, ny_raw;
  logic [10:0] ax_pos, ay_pos;
  logic        ax_dir, ay_dir;
  logic        paddle_hit, miss;

  // Reset takes effect immediately but is released on a clock edge, so all
  // state flops leave reset on the same cycle.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];
  assign tick  = vblnk_in & ~vblnk_d;

  // dir = 1 means right (x) or down (y).
  ball_axis u_axis_x (
    .pos(x_pos), .dir(dir_x), .lo(X_MIN), .hi(X_MAX),
    .raw(nx_raw), .next_pos(ax_pos), .next_dir(ax_dir)
  );

  ball_axis u_axis_y (
    .pos(y_pos), .dir(dir_y), .lo(Y_MIN), .hi(Y_NONE),
    .raw(ny_raw), .next_pos(ay_pos), .next_dir(ay_dir)
  );

  // The paddle only catches a ball that was above its top edge and is
  // crossing it this frame; once below, only the miss test can fire.
  assign paddle_hit = dir_y
                    && (widen(y_pos) + RADIUS_C < PAD_TOP)
                    && (ny_raw + RADIUS_C >= PAD_TOP)
                    && (nx_raw >= widen(paddle_x))
                    && (nx_raw <= widen(paddle_x) + PAD_SPAN);

  assign miss = dir_y && (ny_raw + RADIUS_C >= FLOOR_C);

  // Next-state logic. Nothing changes between ticks; on a miss the
  // position freezes where it was so the lost ball stays visible.
  always_comb begin
    state_nx = state;
    x_nx     = x_pos;
    y_nx     = y_pos;
    dir_x_nx = dir_x;
    dir_y_nx = dir_y;
    lost_nx  = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          x_nx = paddle_x + HALF_PADDLE;
          y_nx = PARK_Y;
          if (start) begin
            state_nx = ST_MOVE;
            dir_x_nx = 1'b1;
            dir_y_nx = 1'b0;
          end
        end
        ST_MOVE: begin
          if (miss && !paddle_hit) begin
            state_nx = ST_LOST;
            lost_nx  = 1'b1;
          end else begin
            x_nx     = ax_pos;
            dir_x_nx = ax_dir;
            if (paddle_hit) begin
              y_nx     = PARK_Y;
              dir_y_nx = 1'b0;
            end else begin
              y_nx     = ay_pos;
              dir_y_nx = ay_dir;
            end
          end
        end
        ST_LOST: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vblnk_d   <= 1'b0;
      x_pos     <= RESET_X;
      y_pos     <= PARK_Y;
      dir_x     <= 1'b1;
      dir_y     <= 1'b0;
      ball_lost <= 1'b0;
      moving    <= 1'b0;
    end else begin
      state     <= state_nx;
      vblnk_d   <= vblnk_in;
      x_pos     <= x_nx;
      y_pos     <= y_nx;
      dir_x     <= dir_x_nx;
      dir_y     <= dir_y_nx;
      ball_lost <= lost_nx;
      moving    <= (state_nx == ST_MOVE);
    end
  end

endmodule
